des_round_controller: RTL and testbench
=======================================

// Module: des_round_controller
// PURPOSE
// - Sequences a single shared DES round datapath: IP/PC-1 load, NUM_ROUNDS Feistel rounds, then the inverse-IP output latch.
// - Drives per-round key-schedule shift commands for both encrypt and decrypt.
// - Sits between the host-side start/ack handshake and the L/R + C/D register datapath of the DES core.
// PARAMETERS
// - NUM_ROUNDS    16  rounds per DES pass; round_idx width is 4, so legal range is 1..16
// - ROUND_CYCLES  1   clock cycles per round (multicycle f-function); legal >= 1
// PORTS
// - clk         in   1  system clock, rising edge
// - n_rst       in   1  asynchronous reset, active low
// - start       in   1  request a new operation; sampled only in IDLE
// - decrypt     in   1  0 = encrypt, 1 = decrypt; captured with start
// - out_ack     in   1  consumer has taken the result; honoured only in DONE
// - busy        out  1  high in every state except IDLE
// - load_ip     out  1  datapath captures IP(block) into L/R and PC-1(key) into C/D
// - round_en    out  1  datapath commits one round (L/R and C/D update)
// - round_idx   out  4  current round 0..NUM_ROUNDS-1; stable for the whole round window
// - key_shift   out  2  C/D rotate amount for this round (0, 1 or 2)
// - key_dir     out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
// - fp_latch    out  1  datapath latches inverse-IP(R16||L16) into the output register
// - done        out  1  result valid; held until out_ack
// - pass_idx    out  2  TDES key select (K1/K2/K3); constant 0 without TDES_EN
// BEHAVIOUR
// - Reset: state IDLE, round counter 0, cycle counter 0, mode 0; all outputs 0.
// - FSM states: IDLE, LOAD, ROUND, FINAL, DONE. All outputs are Moore, decoded from registered state and counters.
// - IDLE -> LOAD when start=1; decrypt is latched into the mode register that cycle.
// - LOAD: load_ip=1 for 1 cycle -> ROUND with round_idx=0 and cycle counter=0.
// - ROUND: round_idx holds for ROUND_CYCLES cycles; round_en=1 only on the last cycle of the window.
//   - That cycle, round_idx increments; after round_idx=NUM_ROUNDS-1 the FSM goes to FINAL.
// - key_shift and key_dir are valid during the whole round window.
// - Encrypt key_shift: 1 at rounds 0, 1, 8, 15; otherwise 2; key_dir=0.
// - Decrypt key_shift: 0 at round 0; 1 at rounds 1, 8, 15; otherwise 2; key_dir=1.
// - FINAL: fp_latch=1 for 1 cycle -> DONE.
// - DONE: done=1 -> IDLE on out_ack=1.
// - Latency, single pass: done rises 1 + NUM_ROUNDS*ROUND_CYCLES + 2 cycles after the start edge (19 at defaults).
// - start while busy (LOAD/ROUND/FINAL/DONE): ignored, not queued.
// - out_ack and start both high in DONE: ack wins, go to IDLE, start dropped; a new start is accepted in the next cycle.
// - out_ack outside DONE: ignored.
// - decrypt changing mid-operation: no effect; only the latched mode is used.
// - n_rst low mid-operation: immediate return to the reset state; the partial result is discarded, done stays 0.
// - Counters never wrap: round_idx is held at 0 outside ROUND.
// CONFIGURATION
// - Macro TDES_EN defined: three passes run per operation, pass_idx = 0, 1, 2.
//   - Pass direction = mode XOR {0,1,0} (E-D-E for encrypt, D-E-D for decrypt).
//   - After FINAL of pass 0 or 1: return to LOAD with pass_idx+1; the datapath reloads from the fp output.
//   - DONE is reached only after pass 2; latency 3*(NUM_ROUNDS*ROUND_CYCLES+2)+1 = 55 cycles at defaults.
// - Macro TDES_EN undefined: single pass; pass_idx tied to 0; no pass counter is synthesised.
// TESTING
// - Reset, then start=1, decrypt=0 for 1 cycle
//   -> load_ip at cycle 1; round_en at cycles 2..17; fp_latch at cycle 18; done=1 at cycle 19.
//   -> key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=0.
// - start with decrypt=1 -> key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=1; done at cycle 19.
// - ROUND_CYCLES=3 -> round_en every 3rd cycle, round_idx stable 3 cycles; done at cycle 1+48+2 = 51.
// - start pulsed at cycle 5 and during DONE; out_ack+start together in DONE
//   -> no restart; IDLE next cycle; a start one cycle later is accepted.
// - n_rst low at round_idx=7 -> all outputs 0 immediately; fresh start afterwards runs a full 19-cycle sequence.
// - TDES_EN, decrypt=0 -> pass_idx 0,1,2; key_dir 0,1,0 per pass; three fp_latch pulses; done at cycle 55.

Source files
------------

// File: rtl/des_round_controller_if.sv
// ---------------------------------------------------------------------------
// des_round_controller_if
// Handshake and datapath-control bundle between the DES round controller
// and its surroundings (host start/ack side and L/R, C/D datapath side).
//
// Signals
//   start      host requests a new operation
//   decrypt    0 = encrypt, 1 = decrypt, sampled together with start
//   out_ack    consumer has taken the result
//   busy       controller is not idle
//   load_ip    datapath loads IP(block) -> L/R and PC-1(key) -> C/D
//   round_en   datapath commits one Feistel round
//   round_idx  current round number
//   key_shift  C/D rotate amount for the current round
//   key_dir    0 = rotate left, 1 = rotate right
//   fp_latch   datapath latches inverse-IP(R16||L16)
//   done       result valid, held until out_ack
//   pass_idx   TDES key select (K1/K2/K3)
//
// Modports
//   master  host / datapath side (drives start, decrypt, out_ack)
//   slave   controller side (drives all control outputs)
// ---------------------------------------------------------------------------
interface des_round_controller_if;
  logic       start;
  logic       decrypt;
  logic       out_ack;
  logic       busy;
  logic       load_ip;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       fp_latch;
  logic       done;
  logic [1:0] pass_idx;

  modport master (
    output start, decrypt, out_ack,
    input  busy, load_ip, round_en, round_idx, key_shift, key_dir,
           fp_latch, done, pass_idx
  );

  modport slave (
    input  start, decrypt, out_ack,
    output busy, load_ip, round_en, round_idx, key_shift, key_dir,
           fp_latch, done, pass_idx
  );
endinterface

// File: rtl/des_round_controller.sv
// ---------------------------------------------------------------------------
// des_round_controller
// Sequences one shared DES round datapath: IP/PC-1 load, NUM_ROUNDS Feistel
// rounds (each ROUND_CYCLES clocks long), then the inverse-IP output latch.
// Also issues the per-round key-schedule rotate commands for encrypt and
// decrypt.
//
// Parameters
//   NUM_ROUNDS    rounds per pass, 1..16 (round_idx is 4 bits)
//   ROUND_CYCLES  clocks per round, >= 1
//
// Ports
//   clk    system clock, rising edge
//   n_rst  asynchronous reset, active low
//   bus    des_round_controller_if.slave (handshake + datapath controls)
//
// Optional feature
//   TDES_EN  when defined, runs three passes per operation (E-D-E for
//            encrypt, D-E-D for decrypt) and drives pass_idx 0,1,2.
//            When undefined, single pass and pass_idx is tied to 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; mode is captured on acceptance
// LOAD   | load_ip for one cycle
// ROUND  | round window; round_en on the last cycle of each window
// FINAL  | fp_latch for one cycle (TDES: back to LOAD until pass 2)
// DONE   | done held until out_ack
// ---------------------------------------------------------------------------
module des_round_controller #(
  parameter int NUM_ROUNDS   = 16,
  parameter int ROUND_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  des_round_controller_if.slave  bus
);

  localparam int             CW         = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0]  CYC_LAST   = CW'(ROUND_CYCLES - 1);
  localparam logic [3:0]     ROUND_LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [3:0]     round_cnt, round_nxt;
  logic [CW-1:0]  cyc_cnt, cyc_nxt;
  logic           mode, mode_nxt;

  logic           last_cyc;
  logic           last_round;
  logic           pass_last;
  logic           pass_dir;

  assign last_cyc   = (cyc_cnt == CYC_LAST);
  assign last_round = (round_cnt == ROUND_LAST);

`ifdef TDES_EN
  logic [1:0] pass_cnt, pass_nxt;

  assign pass_last = (pass_cnt == 2'd2);
  // middle pass runs the opposite direction: E-D-E or D-E-D
  assign pass_dir  = mode ^ (pass_cnt == 2'd1);
`else
  assign pass_last = 1'b1;
  assign pass_dir  = mode;
`endif

  // -------------------------------------------------------------------------
  // state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      round_cnt <= '0;
      cyc_cnt   <= '0;
      mode      <= 1'b0;
`ifdef TDES_EN
      pass_cnt  <= 2'd0;
`endif
    end else begin
      state     <= state_nxt;
      round_cnt <= round_nxt;
      cyc_cnt   <= cyc_nxt;
      mode      <= mode_nxt;
`ifdef TDES_EN
      pass_cnt  <= pass_nxt;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // next-state and counter update
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    round_nxt = '0;
    cyc_nxt   = '0;
    mode_nxt  = mode;
`ifdef TDES_EN
    pass_nxt  = pass_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_LOAD;
          mode_nxt  = bus.decrypt;
`ifdef TDES_EN
          pass_nxt  = 2'd0;
`endif
        end
      end

      S_LOAD: begin
        state_nxt = S_ROUND;
      end

      S_ROUND: begin
        if (last_cyc) begin
          if (last_round) begin
            state_nxt = S_FINAL;
          end else begin
            round_nxt = round_cnt + 4'd1;
          end
        end else begin
          round_nxt = round_cnt;
          cyc_nxt   = cyc_cnt + CW'(1);
        end
      end

      S_FINAL: begin
        if (pass_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_LOAD;
`ifdef TDES_EN
          pass_nxt  = pass_cnt + 2'd1;
`endif
        end
      end

      S_DONE: begin
        // ack has priority over a coincident start; the start is dropped
        if (bus.out_ack) begin
          state_nxt = S_IDLE;
`ifdef TDES_EN
          pass_nxt  = 2'd0;
`endif
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Moore outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.load_ip   = 1'b0;
    bus.round_en  = 1'b0;
    bus.round_idx = 4'd0;
    bus.key_shift = 2'd0;
    bus.key_dir   = 1'b0;
    bus.fp_latch  = 1'b0;
    bus.done      = 1'b0;
`ifdef TDES_EN
    bus.pass_idx  = pass_cnt;
`else
    bus.pass_idx  = 2'd0;
`endif

    case (state)
      S_LOAD:  bus.load_ip = 1'b1;
      S_ROUND: begin
        bus.round_en  = last_cyc;
        bus.round_idx = round_cnt;
        bus.key_dir   = pass_dir;
        // decrypt round 0 uses K16 = C0/D0 directly, hence no rotate
        if (round_cnt == 4'd0) begin
          bus.key_shift = pass_dir ? 2'd0 : 2'd1;
        end else if (round_cnt == 4'd1 || round_cnt == 4'd8 || round_cnt == 4'd15) begin
          bus.key_shift = 2'd1;
        end else begin
          bus.key_shift = 2'd2;
        end
      end
      S_FINAL: bus.fp_latch = 1'b1;
      S_DONE:  bus.done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_des_round_controller.sv
// ---------------------------------------------------------------------------
// tb_des_round_controller
// Directed bench for des_round_controller. Two instances share the clock and
// reset: one with default parameters, one with ROUND_CYCLES = 3. Expected
// per-cycle control vectors come from the cycle timeline of the controller
// (load, rounds, fp latch, done) and the hand-written key-shift tables.
// Honours TDES_EN (three passes) if defined.
// ---------------------------------------------------------------------------
module tb_des_round_controller;

`ifdef TDES_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int NUM_ROUNDS = 16;

  logic clk;
  logic n_rst;

  des_round_controller_if bus ();
  des_round_controller_if bus3 ();

  des_round_controller dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  des_round_controller #(.ROUND_CYCLES(3)) dut3 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, load_ip, round_en, fp_latch, done, key_dir, key_shift, round_idx, pass_idx}
  logic [13:0] obs;
  logic [13:0] obs3;
  assign obs  = {bus.busy, bus.load_ip, bus.round_en, bus.fp_latch, bus.done,
                 bus.key_dir, bus.key_shift, bus.round_idx, bus.pass_idx};
  assign obs3 = {bus3.busy, bus3.load_ip, bus3.round_en, bus3.fp_latch, bus3.done,
                 bus3.key_dir, bus3.key_shift, bus3.round_idx, bus3.pass_idx};

  int enc_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_shift [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int last_cycle(input int rc);
    return PASSES * (NUM_ROUNDS * rc + 2) + 1;
  endfunction

  // Expected control vector k cycles after the edge that accepted start.
  function automatic logic [13:0] exp_vec(input int k, input bit dec, input int rc);
    int       len;
    int       last;
    int       p;
    int       j;
    int       rw;
    int       r;
    bit       dir;
    logic [13:0] v;
    len  = NUM_ROUNDS * rc + 2;
    last = PASSES * len + 1;
    v    = '0;
    if (k < 1 || k > last) return v;
    v[13] = 1'b1;
    if (k == last) begin
      v[9]   = 1'b1;
      v[1:0] = 2'(PASSES - 1);
      return v;
    end
    p      = (k - 1) / len;
    j      = (k - 1) % len;
    v[1:0] = 2'(p);
    if (j == 0) begin
      v[12] = 1'b1;
    end else if (j == len - 1) begin
      v[10] = 1'b1;
    end else begin
      rw      = j - 1;
      r       = rw / rc;
      dir     = dec ^ (p == 1);
      v[11]   = (rw % rc) == (rc - 1);
      v[8]    = dir;
      v[7:6]  = dir ? 2'(dec_shift[r]) : 2'(enc_shift[r]);
      v[5:2]  = 4'(r);
    end
    return v;
  endfunction

  // Caller sets bus.start=1 before calling; returns with the DUT in DONE.
  // Mid-operation disturbances: start pulse + decrypt flip, stray out_ack.
  task automatic run_op(input string name, input bit dec);
    int last;
    last = last_cycle(1);
    for (int k = 1; k <= last; k++) begin
      tick();
      if (k == 1) bus.start = 1'b0;
      if (k == 5) begin
        bus.start   = 1'b1;
        bus.decrypt = ~dec;
      end
      if (k == 6) begin
        bus.start   = 1'b0;
        bus.decrypt = dec;
      end
      if (k == 8) bus.out_ack = 1'b1;
      if (k == 9) bus.out_ack = 1'b0;
      chk($sformatf("%s k=%0d", name, k), 32'(obs), 32'(exp_vec(k, dec, 1)));
    end
  endtask

  // From DONE: start alone is ignored, then ack+start together returns to
  // IDLE with start dropped. Leaves start=1 so the next edge is accepted.
  task automatic finish_op(input string name, input bit dec);
    bus.start = 1'b1;
    tick();
    chk({name, " done_hold"}, 32'(obs), 32'(exp_vec(last_cycle(1), dec, 1)));
    bus.out_ack = 1'b1;
    tick();
    chk({name, " ack_wins"}, 32'(obs), 32'd0);
    bus.out_ack = 1'b0;
  endtask

  initial begin
    n_rst        = 1'b0;
    bus.start    = 1'b0;
    bus.decrypt  = 1'b0;
    bus.out_ack  = 1'b0;
    bus3.start   = 1'b0;
    bus3.decrypt = 1'b0;
    bus3.out_ack = 1'b0;

    #12;
    chk("reset obs", 32'(obs), 32'd0);
    chk("reset obs3", 32'(obs3), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    bus.out_ack = 1'b1;
    tick();
    chk("idle ack ignored", 32'(obs), 32'd0);
    bus.out_ack = 1'b0;

    // encrypt pass
    bus.start   = 1'b1;
    bus.decrypt = 1'b0;
    run_op("enc", 1'b0);
    finish_op("enc", 1'b0);

    // decrypt accepted on the edge right after the ack
    bus.decrypt = 1'b1;
    run_op("dec", 1'b1);
    finish_op("dec", 1'b1);

    // reset while round_idx = 7
    bus.decrypt = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) bus.start = 1'b0;
      chk($sformatf("pre_rst k=%0d", k), 32'(obs), 32'(exp_vec(k, 1'b0, 1)));
    end
    chk("pre_rst round_idx", 32'(bus.round_idx), 32'd7);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst obs", 32'(obs), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk("post_rst idle", 32'(obs), 32'd0);
    bus.start = 1'b1;
    run_op("rerun", 1'b0);
    bus.out_ack = 1'b1;
    tick();
    chk("rerun ack", 32'(obs), 32'd0);
    bus.out_ack = 1'b0;

    // multicycle rounds
    bus3.start   = 1'b1;
    bus3.decrypt = 1'b0;
    for (int k = 1; k <= last_cycle(3); k++) begin
      tick();
      if (k == 1) bus3.start = 1'b0;
      chk($sformatf("rc3 k=%0d", k), 32'(obs3), 32'(exp_vec(k, 1'b0, 3)));
    end
    chk("rc3 done", 32'(bus3.done), 32'd1);
    bus3.out_ack = 1'b1;
    tick();
    chk("rc3 ack", 32'(obs3), 32'd0);
    bus3.out_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
